// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the RV32I memory-access stage:
//   - funct3 load/store encodings (F3_LB..F3_LHU)
//   - access-size decode and misalignment helper
//   - MA-stage FSM state enum
//   - default AXI region base and response timeout
// -----------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] AXI_BASE_DEF = 32'h4000_0000;
  localparam int          TIMEOUT_DEF  = 255;
  localparam int          TMR_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } ma_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // funct3[2] only selects sign/zero extension; size lives in funct3[1:0].
  function automatic lsu_size_e lsu_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
    case (lsu_size(f3))
      SZ_H:    return a_lo[0];
      SZ_W:    return (a_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Combinational load/store lane handling.
//   Ports:
//     i_funct3   in  3   access size / extension
//     i_addr_lo  in  2   byte offset within the word
//     i_wdata    in  32  store data (rs2)
//     i_rdata    in  32  raw read word (DMEM or AXI response)
//     o_be       out 4   byte enables for the access
//     o_wdata    out 32  lane-replicated store data
//     o_rdata    out 32  extracted and sign/zero-extended load data
// -----------------------------------------------------------------------------
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;
  logic        w_unsigned;

  // Aligned halfwords have a_lo[0]=0, so one byte-granular shift serves B and H.
  assign w_shift    = i_rdata >> {i_addr_lo, 3'b000};
  assign w_unsigned = i_funct3[2];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (lsu_size(i_funct3))
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = w_unsigned ? {24'd0, w_shift[7:0]}
                             : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = w_unsigned ? {16'd0, w_shift[15:0]}
                             : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/ma_stage_stall.sv
// -----------------------------------------------------------------------------
// ma_stage_stall
//   RV32I memory-access stage between EX and WB. Loads/stores below AXI_BASE
//   go to single-cycle local DMEM; at or above go to the AXI bridge
//   request/response port, stalling IF..EX until the response or a timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no AXI access pending; DMEM / non-memory ops flow through
//   REQ     | m_req_valid_o high, request fields frozen, wait for ready
//   RESP    | waiting for m_rsp_valid_i, timeout down-counter running
//
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     valid_i .. addr_d_i        EX/MA pipeline slot (held while stall_o)
//     stall_o                    hold IF..EX
//     valid_o .. addr_d_o        MA/WB pipeline register
//     misalign_o, bus_err_o      single-cycle fault pulses aligned with WB
//     dmem_*                     local DMEM strobes, combinational
//     m_req_*, m_rsp_*           AXI bridge request/response port
// -----------------------------------------------------------------------------
module ma_stage_stall
  import rv32i_pkg::*;
#(
  parameter int          DMEM_AW  = 10,
  parameter logic [31:0] AXI_BASE = AXI_BASE_DEF,
  parameter int          TIMEOUT  = TIMEOUT_DEF
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic                reg_we_i,
  input  logic                mem_we_i,
  input  logic                mem_re_i,
  input  logic [1:0]          wb_sel_i,
  input  logic [2:0]          funct3_i,
  input  logic [31:0]         alu_result_i,
  input  logic [31:0]         data_w_i,
  input  logic [31:0]         pc4_i,
  input  logic [4:0]          addr_d_i,
  output logic                stall_o,
  output logic                valid_o,
  output logic                reg_we_o,
  output logic [1:0]          wb_sel_o,
  output logic [31:0]         alu_result_o,
  output logic [31:0]         load_data_o,
  output logic [31:0]         pc4_o,
  output logic [4:0]          addr_d_o,
  output logic                misalign_o,
  output logic                bus_err_o,
  output logic                dmem_we_o,
  output logic                dmem_re_o,
  output logic [DMEM_AW-1:0]  dmem_addr_o,
  output logic [3:0]          dmem_be_o,
  output logic [31:0]         dmem_wdata_o,
  input  logic [31:0]         dmem_rdata_i,
  output logic                m_req_valid_o,
  input  logic                m_req_ready_i,
  output logic                m_req_we_o,
  output logic [31:0]         m_req_addr_o,
  output logic [3:0]          m_req_be_o,
  output logic [31:0]         m_req_wdata_o,
  input  logic                m_rsp_valid_i,
  input  logic [31:0]         m_rsp_data_i,
  input  logic                m_rsp_err_i
);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

  ma_state_e        r_state;
  ma_state_e        w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;

  logic        w_mem_op;
  logic        w_misalign;
  logic        w_is_axi;
  logic        w_dmem_op;
  logic        w_axi_op;
  logic        w_tc;
  logic        w_stall;
  logic        w_cap_req;
  logic        w_done;
  logic        w_rsp_bad;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_mux;
  logic [31:0] w_ld_data;

  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [3:0]  r_req_be;
  logic [31:0] r_req_wdata;

  // ---------------------------------------------------------------------------
  // Access classification
  // ---------------------------------------------------------------------------
  assign w_mem_op   = valid_i & (mem_we_i | mem_re_i);
  assign w_misalign = w_mem_op & lsu_misaligned(funct3_i, alu_result_i[1:0]);
  assign w_is_axi   = (alu_result_i >= AXI_BASE);
  assign w_dmem_op  = (r_state == ST_IDLE) & w_mem_op & ~w_misalign & ~w_is_axi;
  assign w_axi_op   = (r_state == ST_IDLE) & w_mem_op & ~w_misalign &  w_is_axi;

  assign w_tc = (r_tmr == '0);

  // EX holds alu_result_i/funct3_i during the stall, so the same aligner
  // instance extracts the AXI response word at completion.
  assign w_rdata_mux = (r_state == ST_RESP) ? m_rsp_data_i : dmem_rdata_i;

  lsu_align u_align (
    .i_funct3  (funct3_i),
    .i_addr_lo (alu_result_i[1:0]),
    .i_wdata   (data_w_i),
    .i_rdata   (w_rdata_mux),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_ld_data)
  );

  // ---------------------------------------------------------------------------
  // AXI access FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_stall     = 1'b0;
    w_cap_req   = 1'b0;
    w_done      = 1'b0;
    w_rsp_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_axi_op) begin
          w_stall     = 1'b1;
          w_cap_req   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (m_req_ready_i) begin
          w_state_nxt = ST_RESP;
          w_tmr_nxt   = TMR_LOAD;
        end
      end
      ST_RESP: begin
        // A response in the expiry cycle wins over the timeout.
        if (m_rsp_valid_i) begin
          w_done    = 1'b1;
          w_rsp_bad = m_rsp_err_i;
        end else if (w_tc) begin
          w_done    = 1'b1;
          w_rsp_bad = 1'b1;
        end
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // Request fields are frozen at detection so they stay stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_be    <= '0;
      r_req_wdata <= '0;
    end else if (w_cap_req) begin
      r_req_we    <= mem_we_i;
      r_req_addr  <= alu_result_i;
      r_req_be    <= w_be;
      r_req_wdata <= w_wdata;
    end
  end

  assign m_req_valid_o = (r_state == ST_REQ);
  assign m_req_we_o    = r_req_we;
  assign m_req_addr_o  = r_req_addr;
  assign m_req_be_o    = r_req_be;
  assign m_req_wdata_o = r_req_wdata;

  // ---------------------------------------------------------------------------
  // Combinational outputs. Qualified with rst_n so that every output reads 0
  // while reset is held, even if EX is still presenting an AXI op.
  // ---------------------------------------------------------------------------
  assign stall_o      = rst_n & w_stall;
  assign dmem_we_o    = rst_n & w_dmem_op & mem_we_i;
  assign dmem_re_o    = rst_n & w_dmem_op & mem_re_i;
  assign dmem_addr_o  = (rst_n & w_dmem_op) ? alu_result_i[DMEM_AW+1:2] : '0;
  assign dmem_be_o    = (rst_n & w_dmem_op) ? w_be    : '0;
  assign dmem_wdata_o = (rst_n & w_dmem_op) ? w_wdata : '0;

  // ---------------------------------------------------------------------------
  // MA/WB pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      reg_we_o     <= 1'b0;
      misalign_o   <= 1'b0;
      bus_err_o    <= 1'b0;
      wb_sel_o     <= '0;
      alu_result_o <= '0;
      load_data_o  <= '0;
      pc4_o        <= '0;
      addr_d_o     <= '0;
    end else begin
      wb_sel_o     <= wb_sel_i;
      alu_result_o <= alu_result_i;
      load_data_o  <= w_ld_data;
      pc4_o        <= pc4_i;
      addr_d_o     <= addr_d_i;
      if (w_stall) begin
        valid_o    <= 1'b0;
        reg_we_o   <= 1'b0;
        misalign_o <= 1'b0;
        bus_err_o  <= 1'b0;
      end else begin
        valid_o    <= valid_i;
        reg_we_o   <= valid_i & reg_we_i & ~w_misalign & ~w_rsp_bad;
        misalign_o <= w_misalign;
        bus_err_o  <= w_rsp_bad;
      end
    end
  end

endmodule

// File: tb/tb_ma_stage_stall.sv
module tb_ma_stage_stall;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_i, reg_we_i, mem_we_i, mem_re_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, data_w_i, pc4_i;
  logic [4:0]  addr_d_i;
  logic        stall_o, valid_o, reg_we_o;
  logic [1:0]  wb_sel_o;
  logic [31:0] alu_result_o, load_data_o, pc4_o;
  logic [4:0]  addr_d_o;
  logic        misalign_o, bus_err_o;
  logic        dmem_we_o, dmem_re_o;
  logic [9:0]  dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o, dmem_rdata_i;
  logic        m_req_valid_o, m_req_ready_i, m_req_we_o;
  logic [31:0] m_req_addr_o;
  logic [3:0]  m_req_be_o;
  logic [31:0] m_req_wdata_o;
  logic        m_rsp_valid_i, m_rsp_err_i;
  logic [31:0] m_rsp_data_i;

  ma_stage_stall #(.DMEM_AW(10), .AXI_BASE(32'h4000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .reg_we_i(reg_we_i), .mem_we_i(mem_we_i), .mem_re_i(mem_re_i),
    .wb_sel_i(wb_sel_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
    .data_w_i(data_w_i), .pc4_i(pc4_i), .addr_d_i(addr_d_i),
    .stall_o(stall_o), .valid_o(valid_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
    .alu_result_o(alu_result_o), .load_data_o(load_data_o), .pc4_o(pc4_o),
    .addr_d_o(addr_d_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dmem_we_o(dmem_we_o), .dmem_re_o(dmem_re_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
    .m_req_valid_o(m_req_valid_o), .m_req_ready_i(m_req_ready_i), .m_req_we_o(m_req_we_o),
    .m_req_addr_o(m_req_addr_o), .m_req_be_o(m_req_be_o), .m_req_wdata_o(m_req_wdata_o),
    .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_data_i(m_rsp_data_i), .m_rsp_err_i(m_rsp_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment DMEM (read by the DUT) and the reference model's byte view.
  logic [31:0] tb_mem [1024];
  logic [7:0]  ref_bytes [4096];
  assign dmem_rdata_i = tb_mem[dmem_addr_o];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference load: pick bytes out of a word and extend as RV32I defines.
  function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] off);
    logic [7:0] b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    h = (off < 2'd3) ? {b[int'(off)+1], b[int'(off)]} : 16'h0;
    case (f3)
      3'b000:  return {{24{b[off][7]}}, b[off]};
      3'b100:  return {24'h0, b[off]};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [11:0] a);
    int base;
    base = int'(a) & ~3;
    return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
  endfunction

  task automatic preload(input int idx, input logic [31:0] w);
    tb_mem[idx] = w;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = w[8*i +: 8];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_reg_we"}, reg_we_o, 0);
    chk({tag, "_misalign"}, misalign_o, 0);
    chk({tag, "_bus_err"}, bus_err_o, 0);
    chk({tag, "_load_data"}, load_data_o, 0);
    chk({tag, "_alu"}, alu_result_o, 0);
    chk({tag, "_pc4"}, pc4_o, 0);
    chk({tag, "_dmem_we"}, dmem_we_o, 0);
    chk({tag, "_dmem_re"}, dmem_re_o, 0);
    chk({tag, "_dmem_be"}, dmem_be_o, 0);
    chk({tag, "_req_valid"}, m_req_valid_o, 0);
    chk({tag, "_req_addr"}, m_req_addr_o, 0);
  endtask

  // One EX/MA instruction; entered and left just after a rising edge.
  // rsp_dly = RESP-cycle index of the response beat (> TMO means none).
  task automatic do_op(input bit v, input bit we, input bit re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input bit rwe,
                       input int rdy_dly, input int rsp_dly, input bit rsp_err,
                       input logic [31:0] rsp_data);
    int n;
    logic [1:0] off;
    bit memop, mis, axi, dm, ok, rsp, done;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_ld;
    logic [1:0] ws;
    logic [31:0] pc4;
    logic [4:0] rd;
    bit cap_we;
    logic [9:0] cap_a;
    logic [3:0] cap_be;
    logic [31:0] cap_wd;

    ws = 2'($urandom); pc4 = $urandom; rd = 5'($urandom);
    valid_i = v; mem_we_i = we; mem_re_i = re; funct3_i = f3; alu_result_i = a;
    data_w_i = d; reg_we_i = rwe; wb_sel_i = ws; pc4_i = pc4; addr_d_i = rd;
    m_req_ready_i = 1'b0;

    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = a[1:0];
    memop = v && (we || re);
    mis   = memop && ((n == 2 && off[0]) || (n == 4 && off != 2'b00));
    axi   = memop && !mis && (a >= 32'h4000_0000);
    dm    = memop && !mis && !axi;
    e_be  = 4'b0000;
    if (!mis) for (int i = 0; i < n; i++) e_be[int'(off)+i] = 1'b1;
    e_wd  = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
    e_ld  = 32'h0;

    // Response noise outside RESP must be ignored.
    m_rsp_valid_i = 1'($urandom); m_rsp_err_i = 1'($urandom); m_rsp_data_i = $urandom;

    if (!axi) begin
      if (dm && re) e_ld = mdl_load(f3, ref_word(a[11:0]), off);
      @(negedge clk);
      chk("stall", stall_o, 0);
      chk("dmem_we", dmem_we_o, dm && we);
      chk("dmem_re", dmem_re_o, dm && re);
      chk("req_valid_idle", m_req_valid_o, 0);
      if (dm) begin
        chk("dmem_addr", dmem_addr_o, a[11:2]);
        chk("dmem_be", dmem_be_o, e_be);
        if (we) chk("dmem_wdata", dmem_wdata_o, e_wd);
      end
      cap_we = dmem_we_o; cap_a = dmem_addr_o; cap_be = dmem_be_o; cap_wd = dmem_wdata_o;
      @(posedge clk);
      if (cap_we)
        for (int i = 0; i < 4; i++) if (cap_be[i]) tb_mem[cap_a][8*i +: 8] = cap_wd[8*i +: 8];
      if (dm && we)
        for (int i = 0; i < n; i++) ref_bytes[int'(a[11:0])+i] = d[8*i +: 8];
      #1;
      chk("valid_o", valid_o, v);
      chk("reg_we_o", reg_we_o, v && rwe && !mis);
      chk("misalign_o", misalign_o, mis);
      chk("bus_err_o", bus_err_o, 0);
      chk("alu_result_o", alu_result_o, a);
      chk("pc4_o", pc4_o, pc4);
      chk("addr_d_o", addr_d_o, rd);
      chk("wb_sel_o", wb_sel_o, ws);
      if (dm && re) chk("load_dmem", load_data_o, e_ld);
    end else begin
      @(negedge clk);
      chk("axi_detect_stall", stall_o, 1);
      chk("axi_detect_req", m_req_valid_o, 0);
      chk("axi_no_dmem", dmem_we_o | dmem_re_o, 0);
      @(posedge clk); #1;
      chk("axi_bubble0", valid_o, 0);
      for (int r = 0; r <= rdy_dly; r++) begin
        m_req_ready_i = (r == rdy_dly);
        m_rsp_valid_i = 1'($urandom); m_rsp_err_i = 1'($urandom); m_rsp_data_i = $urandom;
        @(negedge clk);
        chk("req_valid", m_req_valid_o, 1);
        chk("req_stall", stall_o, 1);
        chk("req_addr", m_req_addr_o, a);
        chk("req_we", m_req_we_o, we);
        chk("req_be", m_req_be_o, e_be);
        if (we) chk("req_wdata", m_req_wdata_o, e_wd);
        @(posedge clk); #1;
        chk("req_bubble", valid_o, 0);
      end
      m_req_ready_i = 1'b0;
      done = 1'b0;
      for (int k = 0; !done && k <= TMO; k++) begin
        rsp  = (k == rsp_dly);
        done = rsp || (k == TMO);
        m_rsp_valid_i = rsp;
        m_rsp_err_i   = rsp ? rsp_err : 1'($urandom);
        m_rsp_data_i  = rsp ? rsp_data : $urandom;
        @(negedge clk);
        chk("resp_stall", stall_o, !done);
        chk("resp_req_valid", m_req_valid_o, 0);
        @(posedge clk); #1;
        if (!done) chk("resp_bubble", valid_o, 0);
        else begin
          ok = rsp && !rsp_err;
          chk("axi_valid_o", valid_o, 1);
          chk("axi_reg_we", reg_we_o, rwe && ok);
          chk("axi_bus_err", bus_err_o, !ok);
          chk("axi_misalign", misalign_o, 0);
          chk("axi_alu", alu_result_o, a);
          chk("axi_pc4", pc4_o, pc4);
          if (ok && re) chk("axi_load", load_data_o, mdl_load(f3, rsp_data, off));
        end
      end
    end
    m_rsp_valid_i = 1'b0; m_rsp_err_i = 1'b0;
  endtask

  initial begin
    logic [31:0] w, a, d;
    logic [2:0]  f3;
    int          kind;
    bit          st;
    logic [2:0]  ld_f3 [5];

    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      preload(i, w);
    end
    rst_n = 1'b0;
    valid_i = 0; reg_we_i = 0; mem_we_i = 0; mem_re_i = 0; wb_sel_i = 0; funct3_i = 0;
    alu_result_i = 0; data_w_i = 0; pc4_i = 0; addr_d_i = 0;
    m_req_ready_i = 0; m_rsp_valid_i = 0; m_rsp_err_i = 0; m_rsp_data_i = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // LW from DMEM
    preload(4, 32'h8765_4321);
    do_op(1, 0, 1, 3'b010, 32'h0000_0010, 0, 1, 0, 0, 0, 0);
    chk("t1_lw", load_data_o, 32'h8765_4321);
    // LB / LBU sign vs zero extension
    preload(4, 32'h80FF_FFFF);
    do_op(1, 0, 1, 3'b000, 32'h0000_0013, 0, 1, 0, 0, 0, 0);
    chk("t2_lb", load_data_o, 32'hFFFF_FF80);
    do_op(1, 0, 1, 3'b100, 32'h0000_0013, 0, 1, 0, 0, 0, 0);
    chk("t2_lbu", load_data_o, 32'h0000_0080);
    // SH upper half, then read back
    do_op(1, 1, 0, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 0, 0, 0, 0, 0);
    do_op(1, 0, 1, 3'b101, 32'h0000_0006, 0, 1, 0, 0, 0, 0);
    chk("t3_readback", load_data_o, 32'h0000_ABCD);
    // AXI LW: ready on 2nd REQ cycle, response on 3rd RESP cycle
    do_op(1, 0, 1, 3'b010, 32'h4000_0000, 0, 1, 1, 2, 0, 32'hDEAD_BEEF);
    chk("t4_axi_lw", load_data_o, 32'hDEAD_BEEF);
    // AXI timeout, then response in the expiry cycle
    do_op(1, 0, 1, 3'b010, 32'h4000_0004, 0, 1, 0, TMO + 1, 0, 0);
    do_op(1, 0, 1, 3'b010, 32'h4000_0008, 0, 1, 0, TMO, 0, 32'hCAFE_F00D);
    chk("t5_expiry_rsp", load_data_o, 32'hCAFE_F00D);
    // Back-to-back AXI store right after
    do_op(1, 1, 0, 3'b000, 32'h4000_0011, 32'h0000_00A5, 0, 0, 0, 0, 0);
    // Misaligned LH
    do_op(1, 0, 1, 3'b001, 32'h0000_0001, 0, 1, 0, 0, 0, 0);

    // Reset while in REQ
    valid_i = 1; mem_re_i = 1; mem_we_i = 0; funct3_i = 3'b010; alu_result_i = 32'h4000_0100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_in_req", m_req_valid_o, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t6_rst");
    valid_i = 0; mem_re_i = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      st   = 1'($urandom);
      f3   = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      d    = $urandom;
      if (kind < 2) a = $urandom;
      else if (kind < 7) a = (kind == 6 && t % 5 == 0) ? (32'h3FFF_FFFC | 32'($urandom_range(0, 3)))
                                                       : 32'($urandom_range(0, 4095));
      else a = (t % 7 == 0) ? 32'h4000_0000 : $urandom_range(32'h4000_0000, 32'hFFFF_FFFF);
      do_op(($urandom_range(0, 9) != 0), (kind >= 2) && st, (kind >= 2) && !st, f3, a, d,
            1'($urandom), $urandom_range(0, 3), $urandom_range(0, TMO + 2),
            ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
